// File: rtl/game_pkg.sv
// Shared types and defaults for the runner game-flow controller.
package game_pkg;

   typedef enum logic [2:0] {INIT, COUNT, LOGO, SLIDE, PLAY, OVER} state_e;

   localparam int DEF_LANE_PITCH = 100;
   localparam int DEF_LOGO_STEP  = 30;
   localparam int DEF_SLIDE_STEP = 20;

   function automatic int lane_centre(input int num_lanes);
      return (num_lanes - 1) / 2;
   endfunction

endpackage

// File: rtl/game_sequencer_lane_ctrl.sv
// Player lane control: button edge capture, per-frame pending moves,
// saturating lane counter and the derived horizontal player offset.
module lane_ctrl
   import game_pkg::*;
#(
   parameter int NUM_LANES  = 3,
   parameter int W          = 12,
   parameter int LANE_PITCH = DEF_LANE_PITCH
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick,
   input  logic                         btn_l,
   input  logic                         btn_r,
   input  logic                         move_en,
   input  logic                         centre_load,
   output logic [$clog2(NUM_LANES)-1:0] lane,
   output logic [W-1:0]                 player_hoffset
);

   localparam int LW = $clog2(NUM_LANES);
   localparam logic [LW-1:0] CENTRE = LW'(lane_centre(NUM_LANES));
   localparam logic [LW-1:0] LAST   = LW'(NUM_LANES - 1);

   logic          btn_l_q, btn_r_q;
   logic          pend_l, pend_r;
   logic          edge_l, edge_r;
   logic [LW-1:0] lane_nxt;

   assign edge_l = btn_l & ~btn_l_q;
   assign edge_r = btn_r & ~btn_r_q;

   always_comb begin
      lane_nxt = lane;
      if (centre_load) begin
         lane_nxt = CENTRE;
      end else if (move_en) begin
         if (pend_l && !pend_r && lane != '0)
            lane_nxt = lane - 1'b1;
         else if (pend_r && !pend_l && lane != LAST)
            lane_nxt = lane + 1'b1;
      end
   end

   // An edge arriving on the tick cycle itself is kept for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_l_q        <= 1'b0;
         btn_r_q        <= 1'b0;
         pend_l         <= 1'b0;
         pend_r         <= 1'b0;
         lane           <= CENTRE;
         player_hoffset <= '0;
      end else begin
         btn_l_q        <= btn_l;
         btn_r_q        <= btn_r;
         pend_l         <= tick ? edge_l : (pend_l | edge_l);
         pend_r         <= tick ? edge_r : (pend_r | edge_r);
         lane           <= lane_nxt;
         player_hoffset <= W'((int'(lane) - int'(CENTRE)) * LANE_PITCH);
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Frame-ticked game flow: intro phases, play with lanes/score/lives, game over.
module game_sequencer
   import game_pkg::*;
#(
   parameter int NUM_LANES    = 3,
   parameter int W            = 12,
   parameter int LANE_PITCH   = DEF_LANE_PITCH,
   parameter int COUNT_FRAMES = 5,
   parameter int LOGO_STEP    = DEF_LOGO_STEP,
   parameter int LOGO_END     = 640,
   parameter int SLIDE_START  = 180,
   parameter int SLIDE_END    = 50,
   parameter int SLIDE_STEP   = DEF_SLIDE_STEP,
   parameter int LIVES        = 3,
   parameter int SCORE_W      = 16,
   parameter int OVER_FRAMES  = 120
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic                          btn_l,
   input  logic                          btn_r,
   input  logic [3*NUM_LANES-1:0]        rnd,
   input  logic [NUM_LANES-1:0]          hit,
   input  logic [NUM_LANES-1:0]          coin,
   output state_e                        state,
   output logic [W-1:0]                  logo_voffset,
   output logic [W-1:0]                  player_hoffset,
   output logic [W-1:0]                  player_voffset,
   output logic [NUM_LANES-1:0]          spawn_en,
   output logic                          coin_flip,
   output logic [$clog2(NUM_LANES)-1:0]  lane,
   output logic [SCORE_W-1:0]            score,
   output logic [$clog2(LIVES+1)-1:0]    lives_left
);

   localparam int CMAX = (OVER_FRAMES > COUNT_FRAMES) ? OVER_FRAMES : COUNT_FRAMES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int LVW  = $clog2(LIVES + 1);

   state_e               state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [W-1:0]         logo_nxt, pv_nxt;
   logic [SCORE_W-1:0]   score_nxt;
   logic [LVW-1:0]       lives_nxt;
   logic                 flip_nxt;
   logic [NUM_LANES-1:0] spawn_raw;

   lane_ctrl #(
      .NUM_LANES  (NUM_LANES),
      .W          (W),
      .LANE_PITCH (LANE_PITCH)
   ) u_lane (
      .clk            (clk),
      .rst_n          (rst_n),
      .tick           (tick),
      .btn_l          (btn_l),
      .btn_r          (btn_r),
      .move_en        (tick && state == PLAY),
      .centre_load    (tick && state == INIT),
      .lane           (lane),
      .player_hoffset (player_hoffset)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      logo_nxt  = logo_voffset;
      pv_nxt    = player_voffset;
      score_nxt = score;
      lives_nxt = lives_left;
      flip_nxt  = coin_flip;
      if (tick) begin
         case (state)
            INIT: begin
               cnt_nxt   = CW'(COUNT_FRAMES);
               logo_nxt  = '0;
               pv_nxt    = W'(SLIDE_START);
               score_nxt = '0;
               lives_nxt = LVW'(LIVES);
               state_nxt = COUNT;
            end
            COUNT: begin
               if (cnt != '0) cnt_nxt = cnt - 1'b1;
               else           state_nxt = LOGO;
            end
            LOGO: begin
               if (logo_voffset < W'(LOGO_END)) logo_nxt = logo_voffset + W'(LOGO_STEP);
               else                             state_nxt = SLIDE;
            end
            SLIDE: begin
               if (player_voffset > W'(SLIDE_END)) pv_nxt = player_voffset - W'(SLIDE_STEP);
               else                                state_nxt = PLAY;
            end
            PLAY: begin
               flip_nxt = rnd[0];
               // Collision is judged on the lane held before this tick's move.
               if (hit[lane]) begin
                  lives_nxt = lives_left - 1'b1;
                  if (lives_left <= LVW'(1)) begin
                     state_nxt = OVER;
                     cnt_nxt   = CW'(OVER_FRAMES);
                  end
               end else if (coin[lane] && score != '1) begin
                  score_nxt = score + 1'b1;
               end
            end
            OVER: begin
               if (cnt != '0) cnt_nxt = cnt - 1'b1;
               else           state_nxt = INIT;
            end
            default: state_nxt = INIT;
         endcase
      end
   end

   always_comb begin
      spawn_raw = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
         spawn_raw[i] = &rnd[3*i +: 3];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= INIT;
         cnt            <= '0;
         logo_voffset   <= '0;
         player_voffset <= W'(SLIDE_START);
         score          <= '0;
         lives_left     <= LVW'(LIVES);
         coin_flip      <= 1'b0;
         spawn_en       <= '0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         logo_voffset   <= logo_nxt;
         player_voffset <= pv_nxt;
         score          <= score_nxt;
         lives_left     <= lives_nxt;
         coin_flip      <= flip_nxt;
         spawn_en       <= (state == PLAY) ? spawn_raw : '0;
      end
   end

endmodule
